// File: rtl/pqc_params_pkg.sv
// Shared defaults for the polynomial sampling path and the sampler FSM state type.
package pqc_params_pkg;

  localparam int DEF_P    = 17;
  localparam int DEF_N    = 8;
  localparam int DEF_LOGN = 3;
  localparam int DEF_B    = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FRAME,
    ST_SAMPLE,
    ST_DONE
  } sampler_state_t;

endpackage

// File: rtl/poly_reject_sampler_if.sv
// Random-word input stream plus coefficient write stream toward the polynomial store.
interface poly_reject_sampler_if
  import pqc_params_pkg::*;
#(
  parameter int b = DEF_B
);
  logic [2*b-1:0] rand_in;
  logic           rand_valid;
  logic           rand_ready;
  logic           poly_write;
  logic           coeff_valid;
  logic [b-1:0]   coeff_out;

  modport master (
    input  rand_in, rand_valid,
    output rand_ready, poly_write, coeff_valid, coeff_out
  );

  modport slave (
    output rand_in, rand_valid,
    input  rand_ready, poly_write, coeff_valid, coeff_out
  );
endinterface

// File: rtl/coeff_fifo2.sv
// Two-entry in-order coefficient buffer; head falls through from the pushes when empty.
// Zero-cycle bypass, no internal backpressure: the caller keeps count + pushes - pop <= 2.
module coeff_fifo2
  import pqc_params_pkg::*;
#(
  parameter int b = DEF_B
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         push0,
  input  logic [b-1:0] dat0,
  input  logic         push1,
  input  logic [b-1:0] dat1,
  input  logic         pop,
  output logic         avail,
  output logic [b-1:0] head,
  output logic [1:0]   cnt
);

  logic [b-1:0] mem [2];
  logic [b-1:0] q   [4];
  logic [2:0]   n;

  // Logical queue: stored entries first, then this cycle's pushes in candidate order.
  always_comb begin
    q[0] = mem[0];
    q[1] = mem[1];
    q[2] = '0;
    q[3] = '0;
    n    = {1'b0, cnt};
    if (push0) begin
      q[n[1:0]] = dat0;
      n         = n + 3'd1;
    end
    if (push1) begin
      q[n[1:0]] = dat1;
      n         = n + 3'd1;
    end
  end

  assign avail = (n != 3'd0);
  assign head  = q[0];

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt    <= 2'd0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (pop && avail) begin
      mem[0] <= q[1];
      mem[1] <= q[2];
      cnt    <= 2'(n - 3'd1);
    end else begin
      mem[0] <= q[0];
      mem[1] <= q[1];
      cnt    <= n[1:0];
    end
  end

endmodule

// File: rtl/poly_reject_sampler.sv
// Rejection sampler: splits random words into two candidates, keeps those below p, emits N per frame.
// First coefficient three cycles after start; rand_ready throttles the source, no downstream backpressure.
module poly_reject_sampler
  import pqc_params_pkg::*;
#(
  parameter int p    = DEF_P,
  parameter int N    = DEF_N,
  parameter int logN = DEF_LOGN,
  parameter int b    = DEF_B
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  poly_reject_sampler_if.master bus,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           reject_cnt
);

  localparam int RW = 2 * b;
  localparam logic [logN+1:0] N_W    = (logN+2)'(N);
  localparam logic [logN:0]   LAST_E = (logN+1)'(N - 1);
  localparam logic [b:0]      P_W    = (b+1)'(p);

  sampler_state_t state;

  logic [logN:0]   emitted;
  logic [logN:0]   emitted_next;
  logic [1:0]      fifo_cnt;
  logic [2:0]      cnt_next;
  logic [logN+1:0] issued;
  logic [b-1:0]    c0, c1, head;
  logic            ok0, ok1, xfer, push0, push1, pop, ready_next;
  logic [1:0]      rej_inc;
  logic [16:0]     rej_sum;
  logic [15:0]     reject_next;

  assign c0  = bus.rand_in[b-1:0];
  assign c1  = bus.rand_in[RW-1:b];
  assign ok0 = ({1'b0, c0} < P_W);
  assign ok1 = ({1'b0, c1} < P_W);

  assign issued = (logN+2)'(emitted) + (logN+2)'(fifo_cnt);
  assign xfer   = (state == ST_SAMPLE) && bus.rand_valid && bus.rand_ready;
  // Candidate 1 sees the slot candidate 0 may just have taken; surplus accepts are dropped silently.
  assign push0  = xfer && ok0 && (issued < N_W);
  assign push1  = xfer && ok1 && ((issued + (logN+2)'(push0)) < N_W);

  assign rej_inc     = 2'(xfer && !ok0) + 2'(xfer && !ok1);
  assign rej_sum     = {1'b0, reject_cnt} + 17'(rej_inc);
  assign reject_next = rej_sum[16] ? 16'hFFFF : rej_sum[15:0];

  assign emitted_next = emitted + (logN+1)'(pop);
  assign cnt_next     = 3'(fifo_cnt) + 3'(push0) + 3'(push1) - 3'(pop);
  assign ready_next   = (cnt_next <= 3'd1) &&
                        (((logN+2)'(emitted_next) + (logN+2)'(cnt_next)) < N_W);

  coeff_fifo2 #(.b(b)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clr   ((state == ST_IDLE) && start),
    .push0 (push0),
    .dat0  (c0),
    .push1 (push1),
    .dat1  (c1),
    .pop   (pop),
    .avail (pop),
    .head  (head),
    .cnt   (fifo_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      emitted         <= '0;
      bus.rand_ready  <= 1'b0;
      bus.poly_write  <= 1'b0;
      bus.coeff_valid <= 1'b0;
      bus.coeff_out   <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      reject_cnt      <= '0;
    end else begin
      bus.coeff_valid <= pop;
      if (pop) bus.coeff_out <= head;
      emitted        <= emitted_next;
      bus.poly_write <= 1'b0;
      done           <= 1'b0;
      case (state)
        ST_IDLE: begin
          bus.rand_ready <= 1'b0;
          if (start) begin
            state          <= ST_FRAME;
            bus.poly_write <= 1'b1;
            busy           <= 1'b1;
            reject_cnt     <= '0;
            emitted        <= '0;
          end
        end
        ST_FRAME: begin
          state          <= ST_SAMPLE;
          bus.rand_ready <= 1'b1;
        end
        ST_SAMPLE: begin
          reject_cnt <= reject_next;
          if (pop && (emitted == LAST_E)) begin
            state          <= ST_DONE;
            bus.rand_ready <= 1'b0;
          end else begin
            bus.rand_ready <= ready_next;
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_reject_sampler.sv
// Bench for poly_reject_sampler: directed frames plus random words against a candidate-list model.
module tb_poly_reject_sampler;
  localparam int P = 17;
  localparam int N = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic [15:0] reject_cnt;

  poly_reject_sampler_if #(.b(5)) bus ();

  poly_reject_sampler dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .reject_cnt (reject_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [9:0] words_q[$];
  int exp_q[$];
  int got_q[$];
  int m_acc;
  int m_rej;
  int first_cyc;
  int last_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic logic [9:0] mkw(input int c1, input int c0);
    return 10'((c1 << 5) | c0);
  endfunction

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) words_q.push_back(10'($urandom_range(0, 1023)));
  endtask

  // Reference: every candidate >= P is a reject; the first N accepted ones form the frame.
  task automatic model_word(input logic [9:0] w);
    int c[2];
    c[0] = int'(w[4:0]);
    c[1] = int'(w[9:5]);
    for (int i = 0; i < 2; i++) begin
      if (c[i] >= P) begin
        if (m_rej < 65535) m_rej++;
      end else if (m_acc < N) begin
        exp_q.push_back(c[i]);
        m_acc++;
      end
    end
  endtask

  function automatic int got_at(input int i);
    return (got_q.size() > i) ? got_q[i] : -1;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_rand_ready"},  bus.rand_ready, 0);
    chk({tag, "_poly_write"},  bus.poly_write, 0);
    chk({tag, "_coeff_valid"}, bus.coeff_valid, 0);
    chk({tag, "_coeff_out"},   bus.coeff_out, 0);
    chk({tag, "_busy"},        busy, 0);
    chk({tag, "_done"},        done, 0);
    chk({tag, "_reject_cnt"},  reject_cnt, 0);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge.
  task automatic run_poly(input int vmode, input bit start_mid, input int abort_after);
    bit fin;
    bit v;
    fin = 1'b0;
    got_q.delete();
    exp_q.delete();
    m_acc = 0;
    m_rej = 0;
    first_cyc = -1;
    last_cyc = -1;
    start = 1'b1;
    bus.rand_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc < 300; cyc++) begin
      chk("poly_write", bus.poly_write, (cyc == 1));
      if (bus.coeff_valid) begin
        if (exp_q.size() == 0) chk("extra_coeff", bus.coeff_valid, 0);
        else chk("coeff", bus.coeff_out, exp_q.pop_front());
        got_q.push_back(int'(bus.coeff_out));
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
      end
      if (done) begin
        chk("done_latency", cyc, last_cyc + 1);
        chk("coeff_count", got_q.size(), N);
        chk("reject_cnt", reject_cnt, m_rej);
        chk("busy_at_done", busy, 0);
        fin = 1'b1;
        break;
      end
      chk("busy", busy, 1);
      if (m_acc == N) chk("ready_after_n", bus.rand_ready, 0);
      if (abort_after > 0 && got_q.size() == abort_after) begin
        reset = 1'b1;
        bus.rand_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("abort");
        reset = 1'b0;
        fin = 1'b1;
        break;
      end
      start = start_mid && (cyc == 5);
      case (vmode)
        0:       v = 1'b1;
        1:       v = (cyc % 2) == 1;
        default: v = 1'($urandom_range(0, 1));
      endcase
      bus.rand_valid = v && (words_q.size() > 0);
      bus.rand_in = (words_q.size() > 0) ? words_q[0] : '0;
      if (bus.rand_valid && bus.rand_ready) model_word(words_q.pop_front());
      @(posedge clk);
      @(negedge clk);
    end
    if (!fin) chk("timeout_done", done, 1);
    start = 1'b0;
    bus.rand_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    bus.rand_valid = 1'b0;
    bus.rand_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Best case: all accepted, source always valid.
    words_q.delete();
    words_q.push_back(mkw(2, 1));
    words_q.push_back(mkw(4, 3));
    words_q.push_back(mkw(6, 5));
    words_q.push_back(mkw(8, 7));
    run_poly(0, 1'b0, 0);
    chk("first_coeff_cycle", first_cyc, 3);
    chk("consecutive_span", last_cyc - first_cyc, 7);
    chk("best_reject_cnt", reject_cnt, 0);
    for (int i = 0; i < N; i++) chk("best_value", got_at(i), i + 1);

    // Mixed rejects.
    words_q.delete();
    words_q.push_back(mkw(17, 1));
    words_q.push_back(mkw(31, 2));
    words_q.push_back(mkw(3, 20));
    words_q.push_back(mkw(5, 4));
    words_q.push_back(mkw(7, 6));
    words_q.push_back(mkw(9, 8));
    run_poly(0, 1'b0, 0);
    chk("mixed_reject_cnt", reject_cnt, 3);
    chk("mixed_first", got_at(0), 1);
    chk("mixed_second", got_at(1), 2);
    chk("mixed_third", got_at(2), 3);

    // Boundary around p.
    words_q.delete();
    words_q.push_back(mkw(17, 16));
    words_q.push_back(mkw(0, 17));
    fill_random(40);
    run_poly(0, 1'b0, 0);
    chk("boundary_16", got_at(0), 16);
    chk("boundary_0", got_at(1), 0);

    // Surplus: eighth slot taken by 9, 10 dropped.
    words_q.delete();
    words_q.push_back(mkw(2, 1));
    words_q.push_back(mkw(4, 3));
    words_q.push_back(mkw(6, 5));
    words_q.push_back(mkw(31, 7));
    words_q.push_back(mkw(10, 9));
    run_poly(0, 1'b0, 0);
    chk("surplus_seventh", got_at(6), 7);
    chk("surplus_eighth", got_at(7), 9);
    chk("surplus_reject_cnt", reject_cnt, 1);

    // Toggling valid with an ignored mid-frame start.
    words_q.delete();
    fill_random(60);
    run_poly(1, 1'b1, 0);

    // Reset mid-frame, then a full frame.
    words_q.delete();
    fill_random(60);
    run_poly(2, 1'b0, 4);
    words_q.delete();
    fill_random(60);
    run_poly(2, 1'b0, 0);

    for (int k = 0; k < 4; k++) begin
      words_q.delete();
      fill_random(60);
      run_poly(2, 1'b0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
